// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port word memory.
// Ports: clk, rst_n; if_req/if_addr/if_gnt/if_rvalid (fetch);
//   d_req/d_we/d_addr/d_wdata/d_gnt/d_rvalid (data);
//   rsp_rdata/rsp_err (shared response); mem_we/mem_addr/mem_wdata/mem_rdata.
// Option: define MEM_ARB_RR_EN for round-robin contention resolution.
module mem_arbiter #(
  parameter int MEMSZ      = 64,
  parameter int STARVE_MAX = 4,
  localparam int AW        = $clog2(MEMSZ)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RSP_IF,
    RSP_D
  } state_t;

  state_t      state, state_n;
  logic [3:0]  starve_cnt;
  logic        pick_if;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic        addr_bad;

`ifdef MEM_ARB_RR_EN
  // Port favoured at the next contended cycle; fetch wins first.
  logic rr_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_if <= 1'b1;
    end else if (if_req && d_req) begin
      rr_if <= ~if_gnt;
    end
  end

  assign pick_if = rr_if;
`else
  assign pick_if = (starve_cnt == SMAX);
`endif

  // pick_if only matters when both ports request.
  assign if_gnt  = rst_n & if_req & (~d_req | pick_if);
  assign d_gnt   = rst_n & d_req & (~if_req | ~pick_if);
  assign any_gnt = if_gnt | d_gnt;

  assign sel_addr = d_gnt ? d_addr : if_addr;
  assign addr_bad = (|sel_addr[1:0]) | (|sel_addr[31:AW+2]);

  assign mem_addr  = any_gnt ? sel_addr[AW+1:2] : '0;
  assign mem_wdata = any_gnt ? d_wdata : '0;
  assign mem_we    = d_gnt & d_we & ~addr_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else begin
`ifdef MEM_ARB_RR_EN
      starve_cnt <= '0;
`else
      if (if_req && !if_gnt) begin
        if (starve_cnt != SMAX) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = IDLE;
    unique case (1'b1)
      if_gnt:  state_n = RSP_IF;
      d_gnt:   state_n = RSP_D;
      default: state_n = IDLE;
    endcase
  end

  assign if_rvalid = (state == RSP_IF);
  assign d_rvalid  = (state == RSP_D);

  // Sampled at the grant edge, so writes return the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (any_gnt) begin
      rsp_rdata <= addr_bad ? 32'd0 : mem_rdata;
      rsp_err   <= addr_bad;
    end
  end

endmodule
